// File: rtl/stim_pkg.sv
// State codes and H-bridge switch patterns shared by the stimulation pulse sequencer.
// Switch patterns are packed as {sw1, sw2, sw3, sw4}.
package stim_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PH1  = 3'd1,
        ST_IPG  = 3'd2,
        ST_PH2  = 3'd3,
        ST_DSCH = 3'd4,
        ST_REST = 3'd5
    } state_t;

    localparam logic [3:0] SW_OPEN = 4'b0000;
    localparam logic [3:0] SW_CATH = 4'b1001;  // sw1 + sw4
    localparam logic [3:0] SW_ANOD = 4'b0110;  // sw2 + sw3
    localparam logic [3:0] SW_DSCH = 4'b0101;  // sw2 + sw4, both electrodes to the return rail

    function automatic logic [3:0] sw_pattern(input state_t st, input logic pol);
        logic [3:0] pat;
        pat = SW_OPEN;
        case (st)
            ST_PH1:  pat = pol ? SW_ANOD : SW_CATH;
            ST_PH2:  pat = pol ? SW_CATH : SW_ANOD;
            ST_DSCH: pat = SW_DSCH;
            default: pat = SW_OPEN;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/stim_phase_timer.sv
// Phase duration counter: load N-1 on phase entry, count down, expire while at zero.
// Expire is combinational from the count register; no backpressure.
module stim_phase_timer #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_expire
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (i_load) begin
            cnt <= i_load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign o_expire = (cnt == '0);

endmodule

// File: rtl/stim_phase_sequencer.sv
// Biphasic stimulation pulse-train sequencer driving an H-bridge and current source.
// Outputs registered from the next state, so patterns line up with o_state; no backpressure.
module stim_phase_sequencer
    import stim_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_abort,
    input  logic             i_polarity,
    input  logic [CNT_W-1:0] i_ph1_len,
    input  logic [CNT_W-1:0] i_ipg_len,
    input  logic [CNT_W-1:0] i_ph2_len,
    input  logic [CNT_W-1:0] i_dsch_len,
    input  logic [CNT_W-1:0] i_rest_len,
    input  logic [CNT_W-1:0] i_pulse_cnt,
    output logic             out_sw1_sig,
    output logic             out_sw2_sig,
    output logic             out_sw3_sig,
    output logic             out_sw4_sig,
    output logic             output_ctrl_sig,
    output logic             o_busy,
    output logic             o_done,
    output logic [2:0]       o_state
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cfg_ph1, cfg_ipg, cfg_ph2, cfg_dsch, cfg_rest, cfg_cnt;
    logic             cfg_pol, pol_nxt;
    logic             stop_pend;
    logic [CNT_W-1:0] pulse_num, pulse_inc;
    logic             end_pulse, last_pulse, done_nxt;
    logic             tmr_expire, tmr_load;
    logic [CNT_W-1:0] len_sel, tmr_val;
    logic [3:0]       sw_q;
    logic             ctrl_q, busy_q, done_q;

    assign pulse_inc = pulse_num + CNT_W'(1);
    assign pol_nxt   = (state == ST_IDLE) ? i_polarity : cfg_pol;

    always_comb begin
        state_nxt  = state;
        end_pulse  = 1'b0;
        last_pulse = 1'b0;
        done_nxt   = 1'b0;
        case (state)
            ST_IDLE: if (i_start) state_nxt = ST_PH1;
            ST_PH1:  if (tmr_expire) state_nxt = ST_IPG;
            ST_IPG:  if (tmr_expire) state_nxt = ST_PH2;
            ST_PH2: begin
                if (tmr_expire) begin
                    if (cfg_dsch != '0)      state_nxt = ST_DSCH;
                    else if (cfg_rest != '0) state_nxt = ST_REST;
                    else                     end_pulse = 1'b1;
                end
            end
            ST_DSCH: begin
                if (tmr_expire) begin
                    if (cfg_rest != '0) state_nxt = ST_REST;
                    else                end_pulse = 1'b1;
                end
            end
            ST_REST: if (tmr_expire) end_pulse = 1'b1;
            default: state_nxt = ST_IDLE;
        endcase
        // A stop arriving on the final cycle of a pulse still ends the train there.
        if (end_pulse) begin
            last_pulse = ((cfg_cnt != '0) && (pulse_inc == cfg_cnt)) || stop_pend || i_stop;
            state_nxt  = last_pulse ? ST_IDLE : ST_PH1;
            done_nxt   = last_pulse;
        end
        if (i_abort) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b0;
        end
    end

    // The first PH1 length comes straight from the inputs since the latch happens on the same edge.
    always_comb begin
        len_sel = '0;
        case (state_nxt)
            ST_PH1:  len_sel = (state == ST_IDLE) ? i_ph1_len : cfg_ph1;
            ST_IPG:  len_sel = cfg_ipg;
            ST_PH2:  len_sel = cfg_ph2;
            ST_DSCH: len_sel = cfg_dsch;
            ST_REST: len_sel = cfg_rest;
            default: len_sel = '0;
        endcase
        tmr_val  = (len_sel == '0) ? '0 : len_sel - CNT_W'(1);
        tmr_load = (state_nxt != state);
    end

    stim_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (tmr_load),
        .i_load_val (tmr_val),
        .o_expire   (tmr_expire)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            cfg_ph1   <= '0;
            cfg_ipg   <= '0;
            cfg_ph2   <= '0;
            cfg_dsch  <= '0;
            cfg_rest  <= '0;
            cfg_cnt   <= '0;
            cfg_pol   <= 1'b0;
            stop_pend <= 1'b0;
            pulse_num <= '0;
            sw_q      <= SW_OPEN;
            ctrl_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && i_start && !i_abort) begin
                cfg_ph1   <= i_ph1_len;
                cfg_ipg   <= i_ipg_len;
                cfg_ph2   <= i_ph2_len;
                cfg_dsch  <= i_dsch_len;
                cfg_rest  <= i_rest_len;
                cfg_cnt   <= i_pulse_cnt;
                cfg_pol   <= i_polarity;
                pulse_num <= '0;
            end else if (end_pulse && !i_abort) begin
                pulse_num <= pulse_inc;
            end
            if (i_abort || state_nxt == ST_IDLE) stop_pend <= 1'b0;
            else if (i_stop)                      stop_pend <= 1'b1;
            sw_q   <= sw_pattern(state_nxt, pol_nxt);
            ctrl_q <= (state_nxt == ST_PH1) || (state_nxt == ST_PH2);
            busy_q <= (state_nxt != ST_IDLE);
            done_q <= done_nxt;
        end
    end

    assign out_sw1_sig     = sw_q[3];
    assign out_sw2_sig     = sw_q[2];
    assign out_sw3_sig     = sw_q[1];
    assign out_sw4_sig     = sw_q[0];
    assign output_ctrl_sig = ctrl_q;
    assign o_busy          = busy_q;
    assign o_done          = done_q;
    assign o_state         = state;

endmodule
